// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects writeback data, qualifies the register-file
// write, keeps the last completed write for ID-stage bypass. Optional retired-
// instruction counter is built only when RETIRE_COUNT_EN is defined.
module mem_wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         read_data,
    input  logic [31:0]         pc_plus4,
    input  logic [4:0]          write_reg,
    input  logic                regwrite,
    input  logic [1:0]          memtoreg,
    output logic                out_valid,
    output logic [31:0]         wb_data,
    output logic [4:0]          wb_reg,
    output logic                wb_regwrite,
    output logic                lw_en,
    output logic [4:0]          lw_reg,
    output logic [31:0]         lw_data,
    output logic [RETIRE_W-1:0] retire_count
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  reg_q, reg_d;
    logic        regwrite_q, regwrite_d;
    logic        lw_en_q, lw_en_d;
    logic [4:0]  lw_reg_q, lw_reg_d;
    logic [31:0] lw_data_q, lw_data_d;
    logic [31:0] sel_data_s;

    // Writeback source select
    always_comb begin
        sel_data_s = alu_result;
        case (memtoreg)
            2'b00:   sel_data_s = alu_result;
            2'b01:   sel_data_s = read_data;
            2'b10:   sel_data_s = pc_plus4;
            default: sel_data_s = alu_result;
        endcase
    end

    // Next-state: flush beats stall beats normal load
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        reg_d      = reg_q;
        regwrite_d = regwrite_q;
        lw_en_d    = lw_en_q;
        lw_reg_d   = lw_reg_q;
        lw_data_d  = lw_data_q;
        if (flush) begin
            valid_d    = 1'b0;
            data_d     = 32'd0;
            reg_d      = 5'd0;
            regwrite_d = 1'b0;
            lw_en_d    = 1'b0;
        end else if (stall) begin
            valid_d    = valid_q;
        end else begin
            valid_d    = in_valid;
            data_d     = sel_data_s;
            reg_d      = write_reg;
            // x0 is never written, so it is never a bypass source either
            regwrite_d = in_valid & regwrite & (write_reg != 5'd0);
            if (regwrite_q) begin
                lw_en_d   = 1'b1;
                lw_reg_d  = reg_q;
                lw_data_d = data_q;
            end else begin
                lw_en_d   = lw_en_q;
            end
        end
    end

    // Pipeline and bypass registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= 32'd0;
            reg_q      <= 5'd0;
            regwrite_q <= 1'b0;
            lw_en_q    <= 1'b0;
            lw_reg_q   <= 5'd0;
            lw_data_q  <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            reg_q      <= reg_d;
            regwrite_q <= regwrite_d;
            lw_en_q    <= lw_en_d;
            lw_reg_q   <= lw_reg_d;
            lw_data_q  <= lw_data_d;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] retire_q, retire_d;

    // Count every WB-stage valid instruction leaving on a non-stalled edge
    always_comb begin
        retire_d = retire_q;
        if (!stall && valid_q) begin
            retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end else begin
            retire_d = retire_q;
        end
    end

    // Retire counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= {RETIRE_W{1'b0}};
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = {RETIRE_W{1'b0}};
`endif

    assign out_valid   = valid_q;
    assign wb_data     = data_q;
    assign wb_reg      = reg_q;
    assign wb_regwrite = regwrite_q;
    assign lw_en       = lw_en_q;
    assign lw_reg      = lw_reg_q;
    assign lw_data     = lw_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected WB state,
// a monitor pops and compares one record after every rising edge.
module tb_mem_wb_stage;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush, in_valid, regwrite;
    logic [31:0]   alu_result, read_data, pc_plus4;
    logic [4:0]    write_reg;
    logic [1:0]    memtoreg;
    logic          out_valid, wb_regwrite, lw_en;
    logic [31:0]   wb_data, lw_data;
    logic [4:0]    wb_reg, lw_reg;
    logic [RW-1:0] retire_count;

    typedef struct {
        logic        ov;
        logic        wrw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        lwen;
        logic [4:0]  lwr;
        logic [31:0] lwd;
        logic [3:0]  rc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_wb_stage #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
        .write_reg(write_reg), .regwrite(regwrite), .memtoreg(memtoreg),
        .out_valid(out_valid), .wb_data(wb_data), .wb_reg(wb_reg),
        .wb_regwrite(wb_regwrite), .lw_en(lw_en), .lw_reg(lw_reg),
        .lw_data(lw_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=0x%08h want=0x%08h", name, idx, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and queue the state expected after the next rising edge
    task automatic step(input logic r, input logic st, input logic fl, input logic iv,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc4,
                        input logic [4:0] wr, input logic rw, input logic [1:0] m2r,
                        input logic e_ov, input logic e_wrw, input logic [4:0] e_wr,
                        input logic [31:0] e_wd, input logic e_lwen, input logic [4:0] e_lwr,
                        input logic [31:0] e_lwd, input logic [3:0] e_rc);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; flush = fl; in_valid = iv;
        alu_result = alu; read_data = rd; pc_plus4 = pc4;
        write_reg = wr; regwrite = rw; memtoreg = m2r;
        e.ov = e_ov; e.wrw = e_wrw; e.wr = e_wr; e.wd = e_wd;
        e.lwen = e_lwen; e.lwr = e_lwr; e.lwd = e_lwd; e.rc = e_rc;
        exp_q.push_back(e);
    endtask

    int vec_idx = 0;

    // Monitor: compare one queued record per rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid",   vec_idx, {31'd0, out_valid},   {31'd0, e.ov});
            chk("wb_regwrite", vec_idx, {31'd0, wb_regwrite}, {31'd0, e.wrw});
            chk("wb_reg",      vec_idx, {27'd0, wb_reg},      {27'd0, e.wr});
            chk("wb_data",     vec_idx, wb_data,              e.wd);
            chk("lw_en",       vec_idx, {31'd0, lw_en},       {31'd0, e.lwen});
            chk("lw_reg",      vec_idx, {27'd0, lw_reg},      {27'd0, e.lwr});
            chk("lw_data",     vec_idx, lw_data,              e.lwd);
`ifdef RETIRE_COUNT_EN
            chk("retire_count", vec_idx, {28'd0, retire_count}, {28'd0, e.rc});
`else
            chk("retire_count", vec_idx, {28'd0, retire_count}, 32'd0);
`endif
            vec_idx++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        alu_result = 32'd0; read_data = 32'd0; pc_plus4 = 32'd0;
        write_reg = 5'd0; regwrite = 1'b0; memtoreg = 2'b00;
        //    rst   st    fl    iv    alu           rd            pc4           wr     rw    m2r      ov    wrw   wr     wd            lwen  lwr    lwd           rc
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        5'd0,  1'b0, 2'b00,   1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h11,       32'hDEADBEEF, 32'h22,       5'd5,  1'b1, 2'b01,   1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h7,        32'h0,        32'h0,        5'd0,  1'b1, 2'b00,   1'b1, 1'b0, 5'd0,  32'h7,        1'b1, 5'd5,  32'hDEADBEEF, 4'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234,     32'h5555,     32'h66,       5'd3,  1'b1, 2'b11,   1'b1, 1'b1, 5'd3,  32'h1234,     1'b1, 5'd5,  32'hDEADBEEF, 4'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA,     32'hBBBB,     32'h104,      5'd31, 1'b1, 2'b10,   1'b1, 1'b1, 5'd31, 32'h104,      1'b1, 5'd3,  32'h1234,     4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h77,       32'h0,        32'h0,        5'd7,  1'b1, 2'b00,   1'b0, 1'b0, 5'd7,  32'h77,       1'b1, 5'd31, 32'h104,      4'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h900D,     32'h0,        5'd9,  1'b1, 2'b01,   1'b1, 1'b1, 5'd9,  32'h900D,     1'b1, 5'd31, 32'h104,      4'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBAD,  32'hBAD,      32'hBAD,      5'd2,  1'b1, 2'b00,   1'b1, 1'b1, 5'd9,  32'h900D,     1'b1, 5'd31, 32'h104,      4'd4);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hBAD,      32'hBAD,      32'hBAD,      5'd2,  1'b1, 2'b00,   1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 32'h104,      4'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44,       32'h0,        32'h0,        5'd4,  1'b1, 2'b00,   1'b1, 1'b1, 5'd4,  32'h44,       1'b0, 5'd31, 32'h104,      4'd4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD,      32'hBAD,      32'hBAD,      5'd6,  1'b1, 2'b00,   1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 32'h104,      4'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD,      32'hBAD,      32'hBAD,      5'd6,  1'b1, 2'b01,   1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hA,        32'h0,        32'h0,        5'd10, 1'b1, 2'b00,   1'b1, 1'b1, 5'd10, 32'hA,        1'b0, 5'd0,  32'h0,        4'd0);
        // 17 more retirements on a 4-bit counter: 16 wraps to 0, the 17th lands on 1
        for (int j = 0; j < 17; j++) begin
            logic [3:0] rc_e;
            rc_e = 4'(j + 1);
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'(j), 32'h0, 32'h0, 5'(j + 1), 1'b0, 2'b00,
                 1'b1, 1'b0, 5'(j + 1), 32'(j), 1'b1, 5'd10, 32'hA, rc_e);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h5,        32'h0,        32'h0,        5'd5,  1'b1, 2'b00,   1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", vec_idx, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
